keccak_squeeze: RTL and testbench

//  Squeeze-side reader for the Keccak-f[1600] state. It takes the flat permuted state, in the same lane layout
//  as the round steps, and streams rate lanes out one 64-bit lane per beat over a valid/ready handshake.

---
 rtl/keccak_pkg.sv | 23 ++
 rtl/keccak_lane_select.sv | 22 ++
 rtl/keccak_squeeze.sv | 168 ++++++++++++++++
 tb/tb_keccak_squeeze.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/keccak_pkg.sv
// Shared Keccak constants, squeeze FSM encoding and lane addressing helper.
package keccak_pkg;

  localparam int unsigned LANE_WIDTH    = 64;
  localparam int unsigned DIM_SIZE      = 5;
  localparam int unsigned NUM_LANES     = DIM_SIZE * DIM_SIZE;
  localparam int unsigned STATE_WIDTH   = NUM_LANES * LANE_WIDTH;
  localparam int unsigned IDX_WIDTH     = 5;
  localparam int unsigned RATE_SHAKE128 = 21;
  localparam int unsigned RATE_SHAKE256 = 17;

  typedef enum logic [1:0] {
    SQ_IDLE      = 2'd0,
    SQ_WAIT_PERM = 2'd1,
    SQ_STREAM    = 2'd2
  } sq_state_e;

  // Bit offset of lane (x,y) within the flat state.
  function automatic int unsigned lane_off(input int unsigned x, input int unsigned y);
    return (y * DIM_SIZE + x) * LANE_WIDTH;
  endfunction

endpackage

// File: rtl/keccak_lane_select.sv
// Combinational N_LANES:1 selector of 64-bit lanes from a flat rate buffer.
module keccak_lane_select
  import keccak_pkg::*;
#(
  parameter int unsigned N_LANES = RATE_SHAKE128
) (
  input  logic [N_LANES*LANE_WIDTH-1:0] lanes_flat,
  input  logic [IDX_WIDTH-1:0]          idx,
  output logic [LANE_WIDTH-1:0]         lane_c
);

  // Out-of-range indices return zero.
  always_comb begin
    lane_c = '0;
    for (int unsigned i = 0; i < N_LANES; i++) begin
      if (idx == IDX_WIDTH'(i)) begin
        lane_c = lanes_flat[lane_off(i % DIM_SIZE, i / DIM_SIZE) +: LANE_WIDTH];
      end
    end
  end

endmodule

// File: rtl/keccak_squeeze.sv
// Keccak squeeze reader: streams rate lanes of the permuted state one lane per
// beat and requests further permutations while output is still owed.
// Optional feature macro: KECCAK_SQUEEZE_ABORT_EN adds an abort input.
module keccak_squeeze
  import keccak_pkg::*;
#(
  parameter int unsigned RATE_LANES = RATE_SHAKE128,
  parameter int unsigned LEN_WIDTH  = 16
) (
  input  logic                   clk,
  input  logic                   rst,
`ifdef KECCAK_SQUEEZE_ABORT_EN
  input  logic                   abort,
`endif
  input  logic                   start,
  input  logic [LEN_WIDTH-1:0]   len_lanes,
  output logic                   perm_req,
  input  logic                   state_valid,
  input  logic [STATE_WIDTH-1:0] state_in_flat,
  output logic [LANE_WIDTH-1:0]  out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   out_last,
  output logic                   busy,
  output logic                   done
);

  localparam int unsigned BUF_WIDTH = RATE_LANES * LANE_WIDTH;

  sq_state_e              state_q, state_d;
  logic [LEN_WIDTH-1:0]   remaining_q, remaining_d;
  logic [IDX_WIDTH-1:0]   lane_idx_q, lane_idx_d;
  logic [BUF_WIDTH-1:0]   buf_q, buf_d;
  logic [LANE_WIDTH-1:0]  out_data_q, out_data_d;
  logic                   out_valid_q, out_valid_d;
  logic                   out_last_q, out_last_d;
  logic                   perm_req_q, perm_req_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic [IDX_WIDTH-1:0]   next_idx;
  logic [LANE_WIDTH-1:0]  next_lane_c;
  logic                   beat;
  logic                   unused_state;

  // Capacity lanes are never read; fold them away explicitly.
  assign unused_state = ^state_in_flat;

  assign next_idx = lane_idx_q + IDX_WIDTH'(1);
  assign beat     = out_valid_q & out_ready;

  keccak_lane_select #(
    .N_LANES (RATE_LANES)
  ) u_lane_select (
    .lanes_flat (buf_q),
    .idx        (next_idx),
    .lane_c     (next_lane_c)
  );

  // Next-state, counter and registered-output computation.
  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    lane_idx_d  = lane_idx_q;
    buf_d       = buf_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    perm_req_d  = 1'b0;
    done_d      = 1'b0;

    case (state_q)
      SQ_IDLE: begin
        if (start) begin
          if (len_lanes == '0) begin
            done_d = 1'b1;
          end else begin
            remaining_d = len_lanes;
            perm_req_d  = 1'b1;
            state_d     = SQ_WAIT_PERM;
          end
        end
      end
      SQ_WAIT_PERM: begin
        if (state_valid) begin
          buf_d       = state_in_flat[BUF_WIDTH-1:0];
          lane_idx_d  = '0;
          out_data_d  = state_in_flat[lane_off(0, 0) +: LANE_WIDTH];
          out_valid_d = 1'b1;
          out_last_d  = (remaining_q == LEN_WIDTH'(1));
          state_d     = SQ_STREAM;
        end
      end
      SQ_STREAM: begin
        if (beat) begin
          remaining_d = remaining_q - LEN_WIDTH'(1);
          lane_idx_d  = next_idx;
          if (remaining_q == LEN_WIDTH'(1)) begin
            state_d     = SQ_IDLE;
            done_d      = 1'b1;
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
          end else if (lane_idx_q == IDX_WIDTH'(RATE_LANES - 1)) begin
            state_d     = SQ_WAIT_PERM;
            perm_req_d  = 1'b1;
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
          end else begin
            out_data_d = next_lane_c;
            out_last_d = (remaining_q == LEN_WIDTH'(2));
          end
        end
      end
      default: begin
        state_d = SQ_IDLE;
      end
    endcase

`ifdef KECCAK_SQUEEZE_ABORT_EN
    if (abort) begin
      state_d     = SQ_IDLE;
      remaining_d = '0;
      lane_idx_d  = '0;
      buf_d       = buf_q;
      out_valid_d = 1'b0;
      out_last_d  = 1'b0;
      perm_req_d  = 1'b0;
      done_d      = 1'b0;
    end
`endif

    busy_d = (state_d != SQ_IDLE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= SQ_IDLE;
      remaining_q <= '0;
      lane_idx_q  <= '0;
      buf_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      perm_req_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      lane_idx_q  <= lane_idx_d;
      buf_q       <= buf_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      perm_req_q  <= perm_req_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign perm_req  = perm_req_q;
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_keccak_squeeze.sv
// Self-checking bench for keccak_squeeze (RATE_LANES=21, LEN_WIDTH=16).
module tb_keccak_squeeze;
  import keccak_pkg::*;

  localparam int unsigned RATE = 21;
  localparam int unsigned LW   = 16;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   start;
  logic [LW-1:0]          len_lanes;
  logic                   perm_req;
  logic                   state_valid;
  logic [STATE_WIDTH-1:0] state_in_flat;
  logic [LANE_WIDTH-1:0]  out_data;
  logic                   out_valid;
  logic                   out_ready;
  logic                   out_last;
  logic                   busy;
  logic                   done;
`ifdef KECCAK_SQUEEZE_ABORT_EN
  logic                   abort;
`endif

  keccak_squeeze #(
    .RATE_LANES (RATE),
    .LEN_WIDTH  (LW)
  ) dut (
    .clk           (clk),
    .rst           (rst),
`ifdef KECCAK_SQUEEZE_ABORT_EN
    .abort         (abort),
`endif
    .start         (start),
    .len_lanes     (len_lanes),
    .perm_req      (perm_req),
    .state_valid   (state_valid),
    .state_in_flat (state_in_flat),
    .out_data      (out_data),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_last      (out_last),
    .busy          (busy),
    .done          (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned len;
    int unsigned stall_beat;
    int unsigned stall_cycles;
    bit          restart;
  } vec_t;

  typedef struct {
    logic [63:0] data;
    logic        last;
  } beat_t;

  int    total = 0;
  int    bad   = 0;
  beat_t sb_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [STATE_WIDTH-1:0] make_state(input logic [63:0] pat);
    logic [STATE_WIDTH-1:0] s;
    s = '0;
    for (int i = 0; i < 25; i++) s[lane_off(i % 5, i / 5) +: 64] = pat | 64'(i);
    return s;
  endfunction

  function automatic logic [63:0] block_pat(input int b);
    return (b % 2 == 0) ? 64'hA5A5_0000_0000_0000 : 64'hBBBB_0000_0000_0000;
  endfunction

  // Full session: scoreboard fed when a state is delivered, drained on accepted beats.
  task automatic run_session(input vec_t v);
    int cyc = 0, beats = 0, perms = 0, blocks = 0, wait_cnt = 0, stall_cnt = 0;
    int pushed = 0, last_cyc = -10, done_cyc = -1;
    bit waiting = 0, fin = 0, restarted = 0;
    beat_t b;
    sb_q.delete();
    @(negedge clk);
    start = 1'b1; len_lanes = LW'(v.len); out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    while (cyc < 600) begin
      state_valid = 1'b0;
      start = 1'b0;
      if (done) begin
        done_cyc = cyc;
        fin = 1;
        break;
      end
      if (perm_req) begin
        perms++;
        waiting = 1;
        wait_cnt = (blocks == 0) ? 0 : 2;
      end
      if (waiting) begin
        if (wait_cnt == 0) begin
          state_in_flat = make_state(block_pat(blocks));
          state_valid = 1'b1;
          for (int j = 0; j < int'(RATE) && pushed < int'(v.len); j++) begin
            b.data = block_pat(blocks) | 64'(j);
            b.last = (pushed + 1 == int'(v.len));
            sb_q.push_back(b);
            pushed++;
          end
          blocks++;
          waiting = 0;
        end else begin
          chk("valid_low_in_wait", 64'(out_valid), 64'd0);
          wait_cnt--;
        end
      end
      if (v.restart && !restarted && beats == 1) begin
        start = 1'b1; len_lanes = LW'(7); restarted = 1;
      end
      out_ready = 1'b1;
      if (v.stall_cycles > 0 && beats == int'(v.stall_beat) - 1 && out_valid &&
          stall_cnt < int'(v.stall_cycles)) begin
        out_ready = 1'b0;
        if (sb_q.size() > 0) chk("stall_hold_data", out_data, sb_q[0].data);
        stall_cnt++;
      end
      if (out_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          chk("unexpected_beat", 64'(beats), 64'(v.len));
        end else begin
          b = sb_q.pop_front();
          chk("beat_data", out_data, b.data);
          chk("beat_last", 64'(out_last), 64'(b.last));
        end
        beats++;
        last_cyc = cyc;
      end
      @(negedge clk);
      cyc++;
    end
    if (!fin) begin
      total++; bad++;
      $display("FAIL session_timeout len=%0d beats=%0d", v.len, beats);
    end
    chk("beat_count", 64'(beats), 64'(v.len));
    chk("perm_count", 64'(perms), 64'((v.len + RATE - 1) / RATE));
    chk("done_latency", 64'(done_cyc), 64'(last_cyc + 1));
    chk("sb_empty", 64'(sb_q.size()), 64'd0);
    chk("idle_valid", 64'(out_valid), 64'd0);
    chk("idle_busy", 64'(busy), 64'd0);
    @(negedge clk);
    chk("done_one_cycle", 64'(done), 64'd0);
  endtask

  // Kill a len=10 session while beat 4 is presented, by rst or abort.
  task automatic kill_test(input bit use_abort);
    int beats = 0;
    bit got = 0;
    bit seen_bad = 0;
    @(negedge clk);
    start = 1'b1; len_lanes = LW'(10); out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c < 100; c++) begin
      state_valid = 1'b0;
      if (perm_req) begin
        state_in_flat = make_state(64'hA5A5_0000_0000_0000);
        state_valid = 1'b1;
      end
      if (out_valid && beats == 3) begin
        got = 1;
        break;
      end
      if (out_valid && out_ready) beats++;
      @(negedge clk);
    end
    if (!got) begin
      total++; bad++;
      $display("FAIL kill_timeout beats=%0d", beats);
    end
    chk("kill_beat4_data", out_data, 64'hA5A5_0000_0000_0003);
`ifdef KECCAK_SQUEEZE_ABORT_EN
    if (use_abort) abort = 1'b1; else rst = 1'b1;
`else
    rst = 1'b1;
`endif
    @(negedge clk);
    rst = 1'b0;
`ifdef KECCAK_SQUEEZE_ABORT_EN
    abort = 1'b0;
`endif
    chk("kill_valid", 64'(out_valid), 64'd0);
    chk("kill_last", 64'(out_last), 64'd0);
    chk("kill_busy", 64'(busy), 64'd0);
    chk("kill_done", 64'(done), 64'd0);
    chk("kill_perm", 64'(perm_req), 64'd0);
    if (!use_abort) chk("kill_data", out_data, 64'd0);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (done || perm_req || out_valid) seen_bad = 1;
    end
    chk("kill_quiet_after", 64'(seen_bad), 64'd0);
  endtask

  vec_t vecs[7];
  bit   seen;

  initial begin
    vecs[0] = '{len: 3,  stall_beat: 0, stall_cycles: 0, restart: 0};
    vecs[1] = '{len: 21, stall_beat: 0, stall_cycles: 0, restart: 0};
    vecs[2] = '{len: 22, stall_beat: 0, stall_cycles: 0, restart: 0};
    vecs[3] = '{len: 5,  stall_beat: 2, stall_cycles: 5, restart: 0};
    vecs[4] = '{len: 1,  stall_beat: 0, stall_cycles: 0, restart: 0};
    vecs[5] = '{len: 3,  stall_beat: 0, stall_cycles: 0, restart: 1};
    vecs[6] = '{len: 43, stall_beat: 3, stall_cycles: 2, restart: 0};

    rst = 1'b1; start = 1'b0; len_lanes = '0; state_valid = 1'b0;
    state_in_flat = '0; out_ready = 1'b0;
`ifdef KECCAK_SQUEEZE_ABORT_EN
    abort = 1'b0;
`endif
    repeat (3) @(negedge clk);
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_data", out_data, 64'd0);
    chk("rst_last", 64'(out_last), 64'd0);
    chk("rst_perm", 64'(perm_req), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    rst = 1'b0;

    // state_valid in IDLE is ignored
    @(negedge clk);
    state_in_flat = make_state(64'hA5A5_0000_0000_0000);
    state_valid = 1'b1;
    @(negedge clk);
    state_valid = 1'b0;
    chk("idle_sv_valid", 64'(out_valid), 64'd0);
    chk("idle_sv_busy", 64'(busy), 64'd0);

    // Zero-length session
    start = 1'b1; len_lanes = '0;
    @(negedge clk);
    start = 1'b0;
    chk("len0_done", 64'(done), 64'd1);
    chk("len0_perm", 64'(perm_req), 64'd0);
    chk("len0_busy", 64'(busy), 64'd0);
    seen = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (done || perm_req || out_valid) seen = 1;
    end
    chk("len0_quiet", 64'(seen), 64'd0);

    for (int i = 0; i < 7; i++) run_session(vecs[i]);

    kill_test(1'b0);
`ifdef KECCAK_SQUEEZE_ABORT_EN
    kill_test(1'b1);
`endif

    run_session(vecs[0]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
